// File: rtl/f8_test_supervisor_pkg.sv
// ----------------------------------------------------------------------------
// f8_supervisor_pkg
// Shared types and helpers for the f8 run supervisor.
//   state_t         : HOLD / RUN / DRAIN / DONE supervisor states
//   fail_code_t     : reported failure cause
//   first_set_index : trap priority encoder, lowest set bit wins
// ----------------------------------------------------------------------------
package f8_supervisor_pkg;

    // Widest trap vector the priority encoder accepts.
    localparam int MAX_TRAP = 64;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FAIL_NONE      = 2'd0,
        FAIL_TRAP      = 2'd1,
        FAIL_HEARTBEAT = 2'd2
    } fail_code_t;

    // Index of the lowest set bit; 0 when nothing is set. Scanning from the
    // top down lets the lowest index overwrite any higher one.
    function automatic int unsigned first_set_index(input logic [MAX_TRAP-1:0] vec);
        int unsigned idx;
        idx = 32'd0;
        for (int i = MAX_TRAP - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = unsigned'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/f8_test_supervisor_if.sv
// ----------------------------------------------------------------------------
// f8_test_supervisor_if
// Bundle between the supervisor and the system(s) it controls.
//   trap[N_TRAP]     system -> supervisor, level trap lines
//   finish_req       system -> supervisor, early-finish request
//   heartbeat        system -> supervisor, liveness pulse
//   sys_reset        supervisor -> system, active-high reset
//   running, done, pass, fail_code[2], trap_id[TIW], cycle_count[CW]
//                    supervisor status outputs
// Modports: slave = supervisor side, master = system / bench side.
// ----------------------------------------------------------------------------
interface f8_test_supervisor_if #(
    parameter int N_TRAP = 1,
    parameter int TIW    = 1,
    parameter int CW     = 11
);
    logic [N_TRAP-1:0] trap;
    logic              finish_req;
    logic              heartbeat;
    logic              sys_reset;
    logic              running;
    logic              done;
    logic              pass;
    logic [1:0]        fail_code;
    logic [TIW-1:0]    trap_id;
    logic [CW-1:0]     cycle_count;

    modport slave (
        input  trap, finish_req, heartbeat,
        output sys_reset, running, done, pass, fail_code, trap_id, cycle_count
    );

    modport master (
        output trap, finish_req, heartbeat,
        input  sys_reset, running, done, pass, fail_code, trap_id, cycle_count
    );
endinterface

// File: rtl/f8_reset_sync.sv
// ----------------------------------------------------------------------------
// f8_reset_sync
// Two-flop reset synchroniser: asserts asynchronously, releases on the second
// rising clock edge after async_rst_n goes high.
//   clk          in  clock
//   async_rst_n  in  raw active-low reset
//   sync_rst_n   out synchronised active-low reset
// ----------------------------------------------------------------------------
module f8_reset_sync (
    input  logic clk,
    input  logic async_rst_n,
    output logic sync_rst_n
);
    logic meta_r;
    logic sync_r;

    // Shift a constant one through two flops once reset is released.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= 1'b1;
            sync_r <= meta_r;
        end
    end

    assign sync_rst_n = sync_r;
endmodule

// File: rtl/f8_test_supervisor.sv
// ----------------------------------------------------------------------------
// f8_test_supervisor
// Run supervisor: sequences the system reset, counts run cycles up to a
// budget, captures the first trap, drains, then reports done/pass/fail_code.
//   clk               in  system clock
//   power_on_reset_n  in  asynchronous active-low reset
//   sup (slave)       trap/finish_req/heartbeat in; sys_reset, running, done,
//                     pass, fail_code, trap_id, cycle_count out (all registered)
// Optional feature: define SUPERVISOR_HEARTBEAT_EN to build the heartbeat
// watchdog (timeout after HB_WINDOW RUN cycles without a heartbeat).
// ----------------------------------------------------------------------------
module f8_test_supervisor
    import f8_supervisor_pkg::*;
#(
    parameter int RESET_CYCLES = 20,
    parameter int RUN_CYCLES   = 2045,
    parameter int DRAIN_CYCLES = 5,
    parameter int N_TRAP       = 1,
    parameter int HB_WINDOW    = 256
) (
    input  logic                 clk,
    input  logic                 power_on_reset_n,
    f8_test_supervisor_if.slave  sup
);
    localparam int TIW = (N_TRAP > 1) ? $clog2(N_TRAP) : 1;
    localparam int CW  = $clog2(RUN_CYCLES + 1);
    localparam int HCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [HCW-1:0] HOLD_LAST   = HCW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]  RUN_LAST    = CW'(RUN_CYCLES - 1);
    localparam logic [DCW-1:0] DRAIN_LAST  = (DRAIN_CYCLES > 0) ? DCW'(DRAIN_CYCLES - 1) : {DCW{1'b0}};
    localparam state_t         AFTER_RUN   = (DRAIN_CYCLES == 0) ? DONE : DRAIN;

    logic             rst_sync_n_s;
    state_t           state_r;
    state_t           next_state_s;
    logic [HCW-1:0]   hold_cnt_r;
    logic [DCW-1:0]   drain_cnt_r;
    logic             trap_hit_s;
    logic             hb_timeout_s;
    logic             run_exit_s;
    logic             hold_end_s;
    logic             drain_end_s;
    logic [MAX_TRAP-1:0] trap_ext_s;

    logic             sys_reset_r, sys_reset_s;
    logic             running_r, running_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;
    fail_code_t       fail_code_r, fail_code_s;
    logic [TIW-1:0]   trap_id_r, trap_id_s;
    logic [CW-1:0]    cycle_count_r, cycle_count_s;

    f8_reset_sync u_reset_sync (
        .clk         (clk),
        .async_rst_n (power_on_reset_n),
        .sync_rst_n  (rst_sync_n_s)
    );

    assign trap_ext_s  = MAX_TRAP'(sup.trap);
    assign trap_hit_s  = |sup.trap;
    assign hold_end_s  = (hold_cnt_r == HOLD_LAST);
    assign drain_end_s = (drain_cnt_r == DRAIN_LAST);
    assign run_exit_s  = trap_hit_s | hb_timeout_s | sup.finish_req |
                         (cycle_count_r == RUN_LAST);

`ifdef SUPERVISOR_HEARTBEAT_EN
    localparam int HBW = $clog2(HB_WINDOW + 1);
    localparam logic [HBW-1:0] HB_LIMIT = HBW'(HB_WINDOW);
    logic [HBW-1:0] hb_cnt_r;

    // Watchdog: held at zero outside RUN (so it is clear on RUN entry) and on
    // every heartbeat; saturates at the window so it cannot wrap.
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            hb_cnt_r <= {HBW{1'b0}};
        end else if ((state_r != RUN) || sup.heartbeat) begin
            hb_cnt_r <= {HBW{1'b0}};
        end else if (hb_cnt_r != HB_LIMIT) begin
            hb_cnt_r <= hb_cnt_r + HBW'(1);
        end else begin
            hb_cnt_r <= hb_cnt_r;
        end
    end

    assign hb_timeout_s = (state_r == RUN) && (hb_cnt_r == HB_LIMIT);
`else
    localparam int hb_window_unused = HB_WINDOW;
    logic hb_unused_s;
    assign hb_unused_s  = sup.heartbeat;
    assign hb_timeout_s = 1'b0;
`endif

    // State register; reset follows the synchronised reset so HOLD counting
    // starts only after the synchroniser has released.
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            state_r <= HOLD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            HOLD: begin
                if (hold_end_s) next_state_s = RUN;
                else            next_state_s = HOLD;
            end
            RUN: begin
                if (run_exit_s) next_state_s = AFTER_RUN;
                else            next_state_s = RUN;
            end
            DRAIN: begin
                if (drain_end_s) next_state_s = DONE;
                else             next_state_s = DRAIN;
            end
            DONE:    next_state_s = DONE;
            default: next_state_s = HOLD;
        endcase
    end

    // Output logic: next values of the registered outputs. Trap beats the
    // heartbeat timeout, which beats finish/budget; captures happen only in RUN.
    always_comb begin
        sys_reset_s   = (next_state_s == HOLD);
        running_s     = (next_state_s == RUN);
        done_s        = (next_state_s == DONE);
        fail_code_s   = fail_code_r;
        trap_id_s     = trap_id_r;
        cycle_count_s = cycle_count_r;
        if (state_r == RUN) begin
            if (trap_hit_s) begin
                fail_code_s = FAIL_TRAP;
                trap_id_s   = TIW'(first_set_index(trap_ext_s));
            end else if (hb_timeout_s) begin
                fail_code_s = FAIL_HEARTBEAT;
            end else begin
                fail_code_s = FAIL_NONE;
            end
            if (run_exit_s) cycle_count_s = cycle_count_r;
            else            cycle_count_s = cycle_count_r + CW'(1);
        end else begin
            cycle_count_s = cycle_count_r;
        end
        pass_s = done_s && (fail_code_s == FAIL_NONE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            sys_reset_r   <= 1'b1;
            running_r     <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_code_r   <= FAIL_NONE;
            trap_id_r     <= {TIW{1'b0}};
            cycle_count_r <= {CW{1'b0}};
        end else begin
            sys_reset_r   <= sys_reset_s;
            running_r     <= running_s;
            done_r        <= done_s;
            pass_r        <= pass_s;
            fail_code_r   <= fail_code_s;
            trap_id_r     <= trap_id_s;
            cycle_count_r <= cycle_count_s;
        end
    end

    // HOLD and DRAIN interval counters, cleared whenever their state is left.
    always_ff @(posedge clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            hold_cnt_r  <= {HCW{1'b0}};
            drain_cnt_r <= {DCW{1'b0}};
        end else begin
            if ((state_r == HOLD) && !hold_end_s) hold_cnt_r <= hold_cnt_r + HCW'(1);
            else                                  hold_cnt_r <= {HCW{1'b0}};
            if ((state_r == DRAIN) && !drain_end_s) drain_cnt_r <= drain_cnt_r + DCW'(1);
            else                                    drain_cnt_r <= {DCW{1'b0}};
        end
    end

    assign sup.sys_reset   = sys_reset_r;
    assign sup.running     = running_r;
    assign sup.done        = done_r;
    assign sup.pass        = pass_r;
    assign sup.fail_code   = fail_code_r;
    assign sup.trap_id     = trap_id_r;
    assign sup.cycle_count = cycle_count_r;
endmodule

// File: tb/tb_f8_test_supervisor.sv
// ----------------------------------------------------------------------------
// tb_f8_test_supervisor
// Directed bench for f8_test_supervisor with N_TRAP=4 and default timing.
// Expected end-of-run results are queued when the stimulus is applied and
// compared when done rises.
// ----------------------------------------------------------------------------
module tb_f8_test_supervisor;
    localparam int N_TRAP       = 4;
    localparam int RESET_CYCLES = 20;
    localparam int RUN_CYCLES   = 2045;
    localparam int DRAIN_CYCLES = 5;
    localparam int HB_WINDOW    = 16;
    localparam int TIW          = (N_TRAP > 1) ? $clog2(N_TRAP) : 1;
    localparam int CW           = $clog2(RUN_CYCLES + 1);

    typedef struct {
        int fc;
        int tid;
        int cc;
        int pass;
        int delta;
    } exp_t;

    logic clk = 1'b0;
    logic power_on_reset_n = 1'b1;
    int   edges = 0;
    int   fall_edge = 0;
    int   tests = 0;
    int   failed = 0;
    exp_t sb[$];

    f8_test_supervisor_if #(.N_TRAP(N_TRAP), .TIW(TIW), .CW(CW)) sup_if ();

    f8_test_supervisor #(
        .RESET_CYCLES (RESET_CYCLES),
        .RUN_CYCLES   (RUN_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .N_TRAP       (N_TRAP),
        .HB_WINDOW    (HB_WINDOW)
    ) dut (
        .clk              (clk),
        .power_on_reset_n (power_on_reset_n),
        .sup              (sup_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sys_reset"},   sup_if.sys_reset,   1);
        check({tag, "_running"},     sup_if.running,     0);
        check({tag, "_done"},        sup_if.done,        0);
        check({tag, "_pass"},        sup_if.pass,        0);
        check({tag, "_fail_code"},   sup_if.fail_code,   0);
        check({tag, "_trap_id"},     sup_if.trap_id,     0);
        check({tag, "_cycle_count"}, sup_if.cycle_count, 0);
    endtask

    // Model of the end-of-run result for an exit taken in RUN cycle cc.
    task automatic push_exp(input int fc, input int tid, input int cc);
        exp_t e;
        e.fc    = fc;
        e.tid   = tid;
        e.cc    = cc;
        e.pass  = (fc == 0) ? 1 : 0;
        e.delta = cc + 1 + DRAIN_CYCLES;
        sb.push_back(e);
    endtask

    // Reset, release, and check that sys_reset falls on edge RESET_CYCLES+2.
    task automatic start_run(input bit trap_in_hold);
        power_on_reset_n  = 1'b0;
        sup_if.trap       = '0;
        sup_if.finish_req = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("rst");
        @(negedge clk);
        power_on_reset_n = 1'b1;
        for (int e = 1; e <= RESET_CYCLES + 1; e++) begin
            @(posedge clk); #1;
            if (trap_in_hold) sup_if.trap = (e < RESET_CYCLES - 1) ? 4'b0110 : 4'b0000;
        end
        check("hold_sys_reset", sup_if.sys_reset, 1);
        check("hold_running",   sup_if.running,   0);
        @(posedge clk); #1;
        check("run_sys_reset",  sup_if.sys_reset,   0);
        check("run_running",    sup_if.running,     1);
        check("run_cc0",        sup_if.cycle_count, 0);
        fall_edge = edges;
    endtask

    task automatic wait_cc(input int target);
        logic [CW-1:0] tgt;
        int n;
        tgt = target[CW-1:0];
        n = 0;
        while (sup_if.cycle_count !== tgt && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        check("cc_reach", sup_if.cycle_count, tgt);
    endtask

    task automatic wait_done();
        exp_t e;
        int n;
        n = 0;
        while (sup_if.done !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", sup_if.done, 1);
        e = sb.pop_front();
        check("done_delay",  edges - fall_edge,  e.delta);
        check("fail_code",   sup_if.fail_code,   e.fc);
        check("trap_id",     sup_if.trap_id,     e.tid);
        check("cycle_count", sup_if.cycle_count, e.cc);
        check("pass",        sup_if.pass,        e.pass);
        check("done_sysrst", sup_if.sys_reset,   0);
        check("done_running", sup_if.running,    0);
        repeat (3) @(posedge clk);
        #1;
        check("done_sticky", sup_if.done,        1);
        check("cc_frozen",   sup_if.cycle_count, e.cc);
    endtask

    initial begin
        sup_if.trap       = '0;
        sup_if.finish_req = 1'b0;
`ifdef SUPERVISOR_HEARTBEAT_EN
        sup_if.heartbeat  = 1'b1;
`else
        sup_if.heartbeat  = 1'b0;
`endif

        // Full budget, no traps.
        start_run(1'b0);
        push_exp(0, 0, RUN_CYCLES - 1);
        wait_done();

        // Two traps at once; lowest index captured; later traps in DRAIN ignored.
        start_run(1'b0);
        wait_cc(100);
        sup_if.trap = 4'b1010;
        push_exp(1, 1, 100);
        @(posedge clk); #1;
        sup_if.trap = 4'b0001;
        check("drain_running", sup_if.running, 0);
        check("drain_done",    sup_if.done,    0);
        wait_done();
        sup_if.trap = 4'b0000;

        // Trap pulsed during HOLD only.
        start_run(1'b1);
        push_exp(0, 0, RUN_CYCLES - 1);
        wait_done();

        // finish_req and trap[0] in the same cycle: trap wins.
        start_run(1'b0);
        wait_cc(30);
        sup_if.trap       = 4'b0001;
        sup_if.finish_req = 1'b1;
        push_exp(1, 0, 30);
        @(posedge clk); #1;
        sup_if.trap       = 4'b0000;
        sup_if.finish_req = 1'b0;
        wait_done();

        // finish_req alone.
        start_run(1'b0);
        wait_cc(40);
        sup_if.finish_req = 1'b1;
        push_exp(0, 0, 40);
        @(posedge clk); #1;
        sup_if.finish_req = 1'b0;
        wait_done();

        // Reset asserted mid-DRAIN, then the full sequence again.
        start_run(1'b0);
        wait_cc(10);
        sup_if.trap = 4'b1100;
        repeat (3) @(posedge clk);
        #1;
        sup_if.trap = 4'b0000;
        check("mid_drain_running", sup_if.running,   0);
        check("mid_drain_done",    sup_if.done,      0);
        check("mid_drain_fc",      sup_if.fail_code, 1);
        check("mid_drain_tid",     sup_if.trap_id,   2);
        #2;
        power_on_reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        start_run(1'b0);
        push_exp(0, 0, RUN_CYCLES - 1);
        wait_done();

`ifdef SUPERVISOR_HEARTBEAT_EN
        // Heartbeat stops at cycle 50: timeout HB_WINDOW cycles later.
        start_run(1'b0);
        wait_cc(50);
        sup_if.heartbeat = 1'b0;
        push_exp(2, 0, 50 + HB_WINDOW);
        wait_done();
        sup_if.heartbeat = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
